count_monitor: RTL and testbench

- Receive-side checker for the 4-bit up/down counter value.
- Samples the count bus on `clock_div` whenever `sample` is high, and infers the counting direction from consecutive samples.
- Locks once the counter has stepped consistently in one direction; after lock it flags illegal jumps and counts them.
- Sits beside the counter and feeds status LEDs and the display logic.

---
 rtl/count_monitor.sv | 118 +++++++++++
 tb/tb_count_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// Receive-side checker for an up/down counter bus: acquires direction, locks, flags illegal jumps.
// Optional wrap-around pulse is built when COUNT_MONITOR_WRAP_FLAG_EN is defined.
module count_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clock_div,
  input  logic             reset,
  input  logic             sample,
  input  logic [WIDTH-1:0] count_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             dir,
  output logic             err,
  output logic             rev,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {ACQ, CHECK, LOCK} state_t;

  // Handshake: count_in is consumed on a rising clock_div edge only when sample is high;
  // there is no back-pressure, every qualified value is classified against the previous one.
  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] delta;
  logic [2:0]       match;
  logic [2:0]       match_nxt;
  logic             cdir;
  logic             step_up;
  logic             step_dn;
  logic             step_bad;

  assign delta    = count_in - prev;
  assign step_up  = (delta == WIDTH'(1));
  assign step_dn  = (delta == {WIDTH{1'b1}});
  assign step_bad = !step_up && !step_dn && (delta != '0);

  // Run length of consecutive same-direction steps while hunting for lock.
  always_comb begin
    match_nxt = match;
    if (step_bad) begin
      match_nxt = 3'd0;
    end else if (step_up || step_dn) begin
      if ((match != 3'd0) && (step_up == cdir)) match_nxt = match + 3'd1;
      else                                      match_nxt = 3'd1;
    end
  end

`ifdef COUNT_MONITOR_WRAP_FLAG_EN
  logic wrap_step;
  assign wrap_step = (step_up && (count_in == '0)) || (step_dn && (count_in == {WIDTH{1'b1}}));
`else
  assign wrap = 1'b0;
`endif

  always_ff @(posedge clock_div or posedge reset) begin
    if (reset) begin
      state   <= ACQ;
      prev    <= '0;
      match   <= 3'd0;
      cdir    <= 1'b0;
      locked  <= 1'b0;
      dir     <= 1'b0;
      err     <= 1'b0;
      rev     <= 1'b0;
      err_cnt <= '0;
`ifdef COUNT_MONITOR_WRAP_FLAG_EN
      wrap    <= 1'b0;
`endif
    end else begin
      err <= 1'b0;
      rev <= 1'b0;
`ifdef COUNT_MONITOR_WRAP_FLAG_EN
      wrap <= 1'b0;
`endif
      if (err_clr) err_cnt <= '0;
      if (sample) begin
        prev <= count_in;
        case (state)
          ACQ: begin
            match <= 3'd0;
            state <= CHECK;
          end
          CHECK: begin
            match <= match_nxt;
            if (step_up || step_dn) cdir <= step_up;
            if (match_nxt == 3'(LOCK_LEN)) begin
              state  <= LOCK;
              locked <= 1'b1;
              dir    <= step_up;
            end
          end
          LOCK: begin
            if ((step_up || step_dn) && (step_up != dir)) begin
              dir <= step_up;
              rev <= 1'b1;
            end
`ifdef COUNT_MONITOR_WRAP_FLAG_EN
            if (wrap_step) wrap <= 1'b1;
`endif
            if (step_bad) begin
              err    <= 1'b1;
              locked <= 1'b0;
              match  <= 3'd0;
              state  <= CHECK;
              // Clear wins over the increment when both land in the same cycle.
              if (!err_clr && (err_cnt != {ERR_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
            end
          end
          default: state <= ACQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Directed plus randomized bench for count_monitor against a run-length reference model.
module tb_count_monitor;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;
  localparam int LL   = 2;
  localparam int EMAX = 255;

  logic         clk = 1'b0;
  logic         reset;
  logic         sample;
  logic [W-1:0] count_in;
  logic         err_clr;
  logic         locked, dir, err, rev, wrap;
  logic [7:0]   err_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit m_active, m_locked, m_dir, m_cdir;
  bit m_err, m_rev, m_wrap;
  int m_prev, m_run, m_cnt;

  count_monitor #(.WIDTH(W), .LOCK_LEN(LL), .ERR_W(8)) dut (
    .clock_div(clk), .reset(reset), .sample(sample), .count_in(count_in),
    .err_clr(err_clr), .locked(locked), .dir(dir), .err(err), .rev(rev),
    .wrap(wrap), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_locked = 0; m_dir = 0; m_cdir = 0;
    m_err = 0; m_rev = 0; m_wrap = 0;
    m_prev = 0; m_run = 0; m_cnt = 0;
  endtask

  task automatic model_step(input int c, input bit clr);
    int  d;
    bit  up, dn, bad;
    d   = (c - m_prev + (MAXV + 1)) % (MAXV + 1);
    up  = (d == 1);
    dn  = (d == MAXV);
    bad = !up && !dn && (d != 0);
    m_err = 0; m_rev = 0; m_wrap = 0;
    if (!m_active) begin
      m_active = 1;
      m_run    = 0;
    end else if (!m_locked) begin
      if (bad) m_run = 0;
      else if (up || dn) begin
        if (m_run > 0 && up == m_cdir) m_run++;
        else begin m_cdir = up; m_run = 1; end
        if (m_run == LL) begin m_locked = 1; m_dir = m_cdir; end
      end
    end else begin
      if ((up || dn) && up != m_dir) begin m_rev = 1; m_dir = up; end
`ifdef COUNT_MONITOR_WRAP_FLAG_EN
      if ((up && c == 0) || (dn && c == MAXV)) m_wrap = 1;
`endif
      if (bad) begin m_err = 1; m_locked = 0; m_run = 0; end
    end
    if (clr) m_cnt = 0;
    else if (m_err && m_cnt < EMAX) m_cnt++;
    m_prev = c;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".locked"},  32'(locked),  32'(m_locked));
    check({tag, ".dir"},     32'(dir),     32'(m_dir));
    check({tag, ".err"},     32'(err),     32'(m_err));
    check({tag, ".rev"},     32'(rev),     32'(m_rev));
    check({tag, ".wrap"},    32'(wrap),    32'(m_wrap));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
  endtask

  task automatic do_sample(input int c, input bit clr, input string tag);
    @(negedge clk);
    sample = 1'b1; count_in = W'(c); err_clr = clr;
    @(posedge clk);
    #1;
    model_step(c, clr);
    check_all(tag);
    sample = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_idle(input string tag);
    @(negedge clk);
    sample = 1'b0; err_clr = 1'b0; count_in = W'($urandom_range(0, MAXV));
    @(posedge clk);
    #1;
    m_err = 0; m_rev = 0; m_wrap = 0;
    check_all(tag);
  endtask

  task automatic relock_up(input string tag);
    for (int i = 0; i < 10 && !(m_locked && m_dir); i++)
      do_sample((m_prev + 1) % (MAXV + 1), 1'b0, tag);
    check({tag, ".relocked"}, 32'(locked && dir), 32'd1);
  endtask

  task automatic bad_step(input bit clr, input string tag);
    do_sample((m_prev + 5) % (MAXV + 1), clr, tag);
  endtask

  initial begin
    int r;
    reset = 1'b1; sample = 1'b0; count_in = '0; err_clr = 1'b0;
    model_reset();
    #1;
    check_all("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Acquire and lock upward
    do_sample(3, 0, "acq3");
    do_sample(4, 0, "acq4");
    check("lock_after4", 32'(locked), 32'd0);
    do_sample(5, 0, "acq5");
    check("lock_after5", 32'(locked && dir), 32'd1);
    do_idle("idle_hold");

    // Walk up through the wrap
    for (int c = 6; c <= 15; c++) do_sample(c, 0, "walk_up");
    do_sample(0, 0, "wrap0");
    do_sample(1, 0, "wrap1");
    for (int c = 2; c <= 7; c++) do_sample(c, 0, "walk7");

    // Reversal
    do_sample(6, 0, "rev6");
    check("rev_pulse", 32'(rev && !dir && locked), 32'd1);
    do_sample(5, 0, "down5");
    do_sample(6, 0, "rev_up6");
    do_sample(7, 0, "up7");

    // Illegal jump then relock
    do_sample(10, 0, "bad10");
    check("bad_err_cnt1", 32'(err_cnt), 32'd1);
    do_sample(11, 0, "re11");
    do_sample(12, 0, "re12");
    check("relock12", 32'(locked && dir), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      do_sample((m_prev + 1) % (MAXV + 1), $urandom_range(0, 24) == 0, "rnd_up");
      else if (r < 70) do_sample((m_prev + MAXV) % (MAXV + 1), $urandom_range(0, 24) == 0, "rnd_dn");
      else if (r < 78) do_sample(m_prev, 0, "rnd_stall");
      else if (r < 90) do_sample((m_prev + $urandom_range(2, MAXV - 1)) % (MAXV + 1),
                                 $urandom_range(0, 24) == 0, "rnd_bad");
      else             do_idle("rnd_idle");
    end

    // Saturate the error counter
    for (int i = 0; i < 300 && m_cnt < EMAX; i++) begin
      relock_up("sat_lock");
      bad_step(0, "sat_bad");
    end
    check("sat_reached", 32'(err_cnt), 32'd255);
    relock_up("sat_lock2");
    bad_step(0, "sat_hold");
    check("sat_stays", 32'(err_cnt), 32'd255);

    // Clear coincident with an error
    relock_up("clr_lock");
    bad_step(1, "clr_bad");
    check("clr_err_pulse", 32'(err), 32'd1);
    check("clr_cnt_zero", 32'(err_cnt), 32'd0);
    relock_up("pre_rst_lock");
    bad_step(0, "pre_rst_bad");
    relock_up("pre_rst_lock2");

    // Asynchronous reset mid-LOCK, between edges
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    @(negedge clk) reset = 1'b0;
    do_sample(9, 0, "post_rst_acq");
    check("post_rst_no_err", 32'(err || locked), 32'd0);
    do_sample(13, 0, "post_rst_check");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
